ham_enc_arbiter: RTL and testbench

HAM_ENC_ARBITER -- requirements
Module: ham_enc_arbiter

---
 rtl/ham_enc_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_ham_enc_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ham_enc_arbiter.sv
// -----------------------------------------------------------------------------
// ham_enc_arbiter
//
// Two-requester arbiter feeding a single Hamming(7,4)+even-parity encoder.
// Each accepted 16-bit word is sent as four 8-bit codewords, nibble 0
// (bits [3:0]) first. The last codeword of a word is flagged with out_last.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Once valid is high, the source holds it and its data until
// the transfer. The output side keeps out_data/out_tag/out_last stable while
// out_valid is high and out_ready is low.
//
// Ports
//   clk                     : single clock, rising edge
//   reset_n                 : synchronous, active-low reset
//   req0_valid / req1_valid : requester word available
//   req0_data  / req1_data  : 16-bit word, nibble 0 = bits [3:0]
//   req0_ready / req1_ready : word accepted when valid & ready
//   out_valid               : codeword available
//   out_ready               : sink accepts codeword when out_valid & out_ready
//   out_data                : {c7..c0}, c7 = even parity over c6..c0
//   out_tag                 : requester that supplied the current word
//   out_last                : high on the 4th codeword of a word
//   words_done0/1           : (HAM_ENC_STATS_EN only) saturating per-requester
//                             counts of completed words
//
// Build option
//   HAM_ENC_STATS_EN : adds the words_done0/words_done1 outputs and counters.
// -----------------------------------------------------------------------------

// Hamming(7,4) encoder with an extra overall even-parity bit in c7.
module ham_74_encoder (
  input  logic [3:0] d,
  output logic [7:0] c
);

  logic [6:0] code7;

  always_comb begin
    code7[0] = d[0] ^ d[1] ^ d[3];
    code7[1] = d[0] ^ d[2] ^ d[3];
    code7[2] = d[0];
    code7[3] = d[1] ^ d[2] ^ d[3];
    code7[4] = d[1];
    code7[5] = d[2];
    code7[6] = d[3];
    c        = {^code7, code7};
  end

endmodule

module ham_enc_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_tag,
  output logic        out_last
`ifdef HAM_ENC_STATS_EN
  ,
  output logic [15:0] words_done0,
  output logic [15:0] words_done1
`endif
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q,   cnt_d;
  logic        rr_q,    rr_d;     // 1 = req1 preferred on a tie
  logic [15:0] word_q,  word_d;
  logic        tag_q,   tag_d;

  logic        grant0;
  logic        grant1;
  logic        accept;
  logic        out_hs;
  logic [3:0]  nibble;
  logic [7:0]  code;

  // ---------------------------------------------------------------------------
  // Arbitration: a lone valid requester wins; on a tie rr_q picks the winner.
  // grant0/grant1 are mutually exclusive by construction.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant1 = req1_valid & (~req0_valid | rr_q);
    grant0 = req0_valid & ~grant1;
  end

  // Ready is only offered in IDLE and never while reset is asserted.
  always_comb begin
    req0_ready = reset_n & (state_q == ST_IDLE) & grant0;
    req1_ready = reset_n & (state_q == ST_IDLE) & grant1;
    accept     = req0_ready | req1_ready;
  end

  // ---------------------------------------------------------------------------
  // Output side. All outputs derive from registered state, so they cannot
  // change while the sink stalls.
  // ---------------------------------------------------------------------------
  always_comb begin
    unique case (cnt_q)
      2'd0:    nibble = word_q[3:0];
      2'd1:    nibble = word_q[7:4];
      2'd2:    nibble = word_q[11:8];
      default: nibble = word_q[15:12];
    endcase
  end

  ham_74_encoder u_enc (
    .d (nibble),
    .c (code)
  );

  always_comb begin
    out_valid = reset_n & (state_q == ST_SEND);
    out_data  = out_valid ? code : 8'h00;
    out_tag   = out_valid & tag_q;
    out_last  = out_valid & (cnt_q == 2'd3);
    out_hs    = out_valid & out_ready;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    word_d  = word_q;
    tag_d   = tag_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          word_d  = grant1 ? req1_data : req0_data;
          tag_d   = grant1;
          cnt_d   = 2'd0;
          // Hand the tie-break to whoever lost this round.
          rr_d    = ~grant1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_hs) begin
          if (cnt_q == 2'd3) begin
            cnt_d   = 2'd0;
            state_d = ST_IDLE;
          end else begin
            cnt_d   = cnt_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset drops any in-flight word: returning to IDLE stops its codewords.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      rr_q    <= 1'b0;
      word_q  <= 16'h0000;
      tag_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      word_q  <= word_d;
      tag_q   <= tag_d;
    end
  end

`ifdef HAM_ENC_STATS_EN
  // ---------------------------------------------------------------------------
  // Completed-word counters, bumped on the out_last handshake and held at
  // 0xFFFF once saturated.
  // ---------------------------------------------------------------------------
  logic [15:0] words_done0_q, words_done0_d;
  logic [15:0] words_done1_q, words_done1_d;
  logic        word_done;

  always_comb begin
    word_done     = out_hs & out_last;
    words_done0_d = words_done0_q;
    words_done1_d = words_done1_q;
    if (word_done && !tag_q && (words_done0_q != 16'hFFFF)) begin
      words_done0_d = words_done0_q + 16'd1;
    end
    if (word_done && tag_q && (words_done1_q != 16'hFFFF)) begin
      words_done1_d = words_done1_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      words_done0_q <= 16'h0000;
      words_done1_q <= 16'h0000;
    end else begin
      words_done0_q <= words_done0_d;
      words_done1_q <= words_done1_d;
    end
  end

  assign words_done0 = words_done0_q;
  assign words_done1 = words_done1_q;
`endif

endmodule

// File: tb/tb_ham_enc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ham_enc_arbiter
//
// Directed scenarios followed by a randomized phase. The reference keeps a
// queue of expected codewords ({tag, last, data}) filled with four entries
// whenever a word is accepted; codewords are computed with a positional
// Hamming construction (parity bit p covers every position j with j&p != 0).
// Define HAM_ENC_STATS_EN to also exercise the word counters.
// -----------------------------------------------------------------------------
module tb_ham_enc_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_data,  req1_data;
  logic        req0_ready, req1_ready;
  logic        out_valid,  out_ready;
  logic [7:0]  out_data;
  logic        out_tag,    out_last;
`ifdef HAM_ENC_STATS_EN
  logic [15:0] words_done0, words_done1;
`endif

  ham_enc_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .out_last   (out_last)
`ifdef HAM_ENC_STATS_EN
    ,
    .words_done0 (words_done0),
    .words_done1 (words_done1)
`endif
  );

  // ---------------- scoreboard state ----------------
  int          errors = 0;
  int          checks = 0;
  logic [9:0]  exp_q[$];     // {tag, last, codeword}
  logic        m_pref;       // 1 = req1 wins a tie
`ifdef HAM_ENC_STATS_EN
  logic [15:0] m_done0, m_done1;
`endif

  // values sampled by the last step(), for directed checks
  logic        obs_r0, obs_r1, obs_valid, obs_tag, obs_last;
  logic [7:0]  obs_data;

  // Positional Hamming(7,4): data at positions 3,5,6,7, parity at 1,2,4.
  function automatic logic [7:0] ham_ref(input logic [3:0] d);
    logic [7:0] pos;
    logic [7:0] c;
    logic       x;
    int         di;
    pos = '0;
    di  = 0;
    for (int j = 1; j < 8; j++) begin
      if (j != 1 && j != 2 && j != 4) begin
        pos[j] = d[di];
        di++;
      end
    end
    for (int p = 1; p < 8; p = p * 2) begin
      x = 1'b0;
      for (int j = 1; j < 8; j++) begin
        if (((j & p) != 0) && (j != p)) x = x ^ pos[j];
      end
      pos[p] = x;
    end
    c[6:0] = pos[7:1];
    c[7]   = ^pos[7:1];
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare at negedge against the reference, then advance
  // the reference across the coming posedge. Inputs are set by the caller
  // before the call (shortly after the previous posedge).
  task automatic step();
    logic       idle, g0, g1, e_valid;
    logic [9:0] e;
    logic [15:0] w;
    @(negedge clk);
    idle    = (exp_q.size() == 0);
    g1      = req1_valid && (!req0_valid || m_pref);
    g0      = req0_valid && !g1;
    e_valid = reset_n && !idle;
    e       = e_valid ? exp_q[0] : 10'h000;

    obs_r0 = req0_ready; obs_r1 = req1_ready; obs_valid = out_valid;
    obs_data = out_data; obs_tag = out_tag;   obs_last = out_last;

    chk("req0_ready", 32'(req0_ready), 32'(reset_n && idle && g0));
    chk("req1_ready", 32'(req1_ready), 32'(reset_n && idle && g1));
    chk("out_valid",  32'(out_valid),  32'(e_valid));
    chk("out_data",   32'(out_data),   32'(e[7:0]));
    chk("out_tag",    32'(out_tag),    32'(e[9]));
    chk("out_last",   32'(out_last),   32'(e[8]));
`ifdef HAM_ENC_STATS_EN
    chk("words_done0", 32'(words_done0), 32'(m_done0));
    chk("words_done1", 32'(words_done1), 32'(m_done1));
`endif

    if (!reset_n) begin
      exp_q.delete();
      m_pref = 1'b0;
`ifdef HAM_ENC_STATS_EN
      m_done0 = 16'h0000;
      m_done1 = 16'h0000;
`endif
    end else if (!idle) begin
      if (out_ready) begin
`ifdef HAM_ENC_STATS_EN
        if (e[8] && !e[9] && m_done0 != 16'hFFFF) m_done0 = m_done0 + 16'd1;
        if (e[8] &&  e[9] && m_done1 != 16'hFFFF) m_done1 = m_done1 + 16'd1;
`endif
        void'(exp_q.pop_front());
      end
    end else if (g0 || g1) begin
      w = g1 ? req1_data : req0_data;
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back({g1, (k == 3), ham_ref(w[4*k +: 4])});
      end
      m_pref = g0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] f21b_codes [4];

  initial begin
    f21b_codes[0] = 8'h55; f21b_codes[1] = 8'h87;
    f21b_codes[2] = 8'h99; f21b_codes[3] = 8'hFF;
    m_pref = 1'b0;
`ifdef HAM_ENC_STATS_EN
    m_done0 = 16'h0000;
    m_done1 = 16'h0000;
`endif
    reset_n = 1'b0; out_ready = 1'b0;
    req0_valid = 1'b0; req0_data = 16'h0000;
    req1_valid = 1'b0; req1_data = 16'h0000;
    #1;

    // Reset state, held with requests present: nothing may be offered.
    req0_valid = 1'b1; req1_valid = 1'b1;
    step();
    chk("rst_out_valid", 32'(obs_valid), 32'(0));
    chk("rst_ready0",    32'(obs_r0),    32'(0));
    step();
    reset_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    // Single requester, 0xF21B, sink always ready.
    out_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 16'hF21B;
    step();
    chk("f21b_accept", 32'(obs_r0), 32'(1));
    req0_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("f21b_code", 32'(obs_data), 32'(f21b_codes[k]));
      chk("f21b_last", 32'(obs_last), 32'(k == 3));
      chk("f21b_tag",  32'(obs_tag),  32'(0));
    end
    step();
    chk("f21b_done", 32'(obs_valid), 32'(0));

    // Tie after reset: req0 first, then req1, then req0 wins the next tie.
    do_reset();
    req0_valid = 1'b1; req0_data = 16'h0000;
    req1_valid = 1'b1; req1_data = 16'hFFFF;
    step();
    chk("tie_grant0", 32'(obs_r0), 32'(1));
    req0_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("tie_code0", 32'(obs_data), 32'(8'h00));
    end
    step();
    chk("tie_grant1", 32'(obs_r1), 32'(1));
    req1_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("tie_code1", 32'(obs_data), 32'(8'hFF));
      chk("tie_tag1",  32'(obs_tag),  32'(1));
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    step();
    chk("tie_again0", 32'(obs_r0), 32'(1));
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (5) step();

    // Stall on the second codeword.
    req0_valid = 1'b1; req0_data = 16'hF21B;
    step();
    req0_valid = 1'b0;
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_hold", 32'(obs_data), 32'(8'h87));
    end
    out_ready = 1'b1;
    step();
    chk("stall_release", 32'(obs_data), 32'(8'h87));
    step();
    chk("stall_next", 32'(obs_data), 32'(8'h99));
    repeat (3) step();

    // Reset one cycle after the second codeword handshake.
    req0_valid = 1'b1; req0_data = 16'h1234;
    step();
    req0_valid = 1'b0;
    step();
    step();
    step();
    reset_n = 1'b0;
    step();
    chk("midrst_valid", 32'(obs_valid), 32'(0));
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("midrst_quiet", 32'(obs_valid), 32'(0));
    end

    // req1 waits through req0's SEND and is taken on the first IDLE cycle.
    req0_valid = 1'b1; req0_data = 16'hA5C3;
    req1_valid = 1'b1; req1_data = 16'h3C5A;
    step();
    chk("wait_grant0", 32'(obs_r0), 32'(1));
    req0_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("wait_r1_low", 32'(obs_r1), 32'(0));
    end
    step();
    chk("wait_grant1", 32'(obs_r1), 32'(1));
    req1_valid = 1'b0;
    repeat (5) step();

`ifdef HAM_ENC_STATS_EN
    // Counters: three words from req1, then saturation.
    do_reset();
    for (int n = 0; n < 3; n++) begin
      req1_valid = 1'b1; req1_data = 16'($urandom);
      step();
      req1_valid = 1'b0;
      repeat (4) step();
    end
    step();
    chk("stats_done1", 32'(words_done1), 32'(3));
    chk("stats_done0", 32'(words_done0), 32'(0));
    force dut.words_done1_q = 16'hFFFF;
    #1;
    release dut.words_done1_q;
    m_done1 = 16'hFFFF;
    req1_valid = 1'b1; req1_data = 16'h0F0F;
    step();
    req1_valid = 1'b0;
    repeat (5) step();
    chk("stats_sat", 32'(words_done1), 32'(16'hFFFF));
`endif

    // Randomized traffic with occasional resets and sink stalls.
    for (int n = 0; n < 600; n++) begin
      reset_n    = ($urandom_range(0, 59) != 0);
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_data  = 16'($urandom);
      req1_data  = 16'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      step();
    end
    reset_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
    repeat (6) step();
    chk("final_drained", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
